// File: rtl/bridge_pkg.sv
// bridge_pkg: shared widths, fill byte and TX state encoding for the SPI-to-UART bridge
package bridge_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] FILL_DEFAULT = 8'hFF;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: show-ahead byte FIFO; a push while full is taken only alongside a pop
module byte_fifo
  import bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_push, w_pop;
  assign empty    = r_wr == r_rd;
  assign full     = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop    = pop && !empty;
  assign w_push   = push && (!full || w_pop);
  assign pop_data = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/spi_to_uart_bridge.sv
// spi_to_uart_bridge: queues SPI bytes toward the UART transmitter and UART bytes
// back toward the SPI slave response register
module spi_to_uart_bridge
  import bridge_pkg::*;
#(
  parameter int               DEPTH     = 4,
  parameter logic [BYTE_W-1:0] FILL_BYTE = FILL_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_rx_done,
  input  logic [BYTE_W-1:0] spi_rx_data,
  input  logic              spi_tx_req,
  output logic [BYTE_W-1:0] spi_tx_data,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_busy,
  input  logic              uart_done,
  input  logic [BYTE_W-1:0] uart_data,
  output logic              tx_ovf,
  output logic              rx_ovf,
  output logic              rx_underrun
);
  tx_state_t r_state, w_next;
  logic [BYTE_W-1:0] w_tx_head, w_rx_head, r_tx_data, r_spi_tx_data;
  logic w_tx_full, w_tx_empty, w_tx_pop;
  logic w_rx_full, w_rx_empty, w_rx_pop;
  logic r_tx_start, r_tx_ovf, r_rx_ovf, r_underrun;

  byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (spi_rx_done),
    .push_data(spi_rx_data),
    .pop      (w_tx_pop),
    .pop_data (w_tx_head),
    .full     (w_tx_full),
    .empty    (w_tx_empty)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (uart_done),
    .push_data(uart_data),
    .pop      (w_rx_pop),
    .pop_data (w_rx_head),
    .full     (w_rx_full),
    .empty    (w_rx_empty)
  );

  assign w_rx_pop = spi_tx_req && !w_rx_empty;

  always_comb begin
    w_next   = r_state;
    w_tx_pop = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_pop = !w_tx_empty && !tx_busy;
        w_next   = w_tx_pop ? LAUNCH : IDLE;
      end
      LAUNCH:    w_next = WAIT_BUSY;
      WAIT_BUSY: w_next = tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: w_next = tx_busy ? WAIT_DONE : IDLE;
    endcase
  end

  // a dropped push is one that arrives full with no pop freeing a slot that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_spi_tx_data <= FILL_BYTE;
      r_tx_ovf      <= 1'b0;
      r_rx_ovf      <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tx_start <= w_next == LAUNCH;
      if (w_tx_pop) r_tx_data <= w_tx_head;
      if (spi_tx_req) r_spi_tx_data <= w_rx_empty ? FILL_BYTE : w_rx_head;
      r_tx_ovf   <= r_tx_ovf | (spi_rx_done & w_tx_full & ~w_tx_pop);
      r_rx_ovf   <= r_rx_ovf | (uart_done & w_rx_full & ~w_rx_pop);
      r_underrun <= r_underrun | (spi_tx_req & w_rx_empty);
    end
  end

  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign spi_tx_data = r_spi_tx_data;
  assign tx_ovf      = r_tx_ovf;
  assign rx_ovf      = r_rx_ovf;
  assign rx_underrun = r_underrun;
endmodule
